// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory between the core load/store path and an
// auxiliary master (program loader / debug port). Grants are combinational
// from the live requests and registered arbitration state. The winning
// request is steered onto the dmem port. Load data is captured into a
// per-requester response register and presented one cycle after the grant.
//
// Parameters:
//   MAX_WAIT  consecutive cycles a requesting aux may lose in fixed-priority
//             mode before it is force-granted. The same bound limits how long
//             an aux lock may starve a requesting core. Legal range 1..255.
//
// Optional feature:
//   DMEM_ARB_RR_EN  when defined, core/aux conflicts are resolved round-robin.
//                   When undefined, the core has fixed priority and the aux
//                   is protected by the wait counter.
//
// Ports:
//   i_clk, i_reset                         clock, async active-high reset
//   i_cReq/i_cWrite/i_cFunct3/i_cAddr/i_cWData   core request
//   o_cGnt, o_stall                        core grant, core PC/pipeline stall
//   o_cRValid, o_cRData                    core load response
//   i_aReq/i_aWrite/i_aFunct3/i_aAddr/i_aWData   aux request
//   i_aLock                                aux burst lock
//   o_aGnt, o_aRValid, o_aRData            aux grant and load response
//   o_memRead, o_memWrite, o_addr, o_funct3, o_dataOut   dmem request port
//   i_memRData                             dmem read data (combinational)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cReq,
  input  logic        i_cWrite,
  input  logic [2:0]  i_cFunct3,
  input  logic [31:0] i_cAddr,
  input  logic [31:0] i_cWData,
  output logic        o_cGnt,
  output logic        o_stall,
  output logic        o_cRValid,
  output logic [31:0] o_cRData,
  input  logic        i_aReq,
  input  logic        i_aWrite,
  input  logic [2:0]  i_aFunct3,
  input  logic [31:0] i_aAddr,
  input  logic [31:0] i_aWData,
  input  logic        i_aLock,
  output logic        o_aGnt,
  output logic        o_aRValid,
  output logic [31:0] o_aRData,
  output logic        o_memRead,
  output logic        o_memWrite,
  output logic [31:0] o_addr,
  output logic [2:0]  o_funct3,
  output logic [31:0] o_dataOut,
  input  logic [31:0] i_memRData
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_AUX  = 2'd2
  } owner_t;

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  owner_t     owner;
  owner_t     owner_next;
  logic [7:0] wait_cnt;
  logic [7:0] wait_next;
  logic [7:0] lock_cnt;
  logic [7:0] lock_next;
  logic       lock_break;
  logic       lock_break_next;
  logic       lock_hold;
  logic       c_gnt;
  logic       a_gnt;

  // Arbitration. A held aux lock outranks everything, except that once the
  // lock has starved a requesting core for MAX_WAIT cycles the core gets one
  // cycle. The cycle after such a break the lock resumes even though the
  // owner register now says CORE; lock_break remembers that. Grants are
  // suppressed while reset is asserted.
  always_comb begin
    c_gnt     = 1'b0;
    a_gnt     = 1'b0;
    lock_hold = i_aReq & i_aLock & ((owner == OWN_AUX) | lock_break);
    if (i_reset) begin
      c_gnt = 1'b0;
      a_gnt = 1'b0;
    end else if (lock_hold) begin
      if (i_cReq && (lock_cnt == MAX_W)) begin
        c_gnt = 1'b1;
      end else begin
        a_gnt = 1'b1;
      end
    end else if (i_cReq && !i_aReq) begin
      c_gnt = 1'b1;
    end else if (!i_cReq && i_aReq) begin
      a_gnt = 1'b1;
    end else if (i_cReq && i_aReq) begin
`ifdef DMEM_ARB_RR_EN
      if (owner == OWN_CORE) begin
        a_gnt = 1'b1;
      end else begin
        c_gnt = 1'b1;
      end
`else
      if (wait_cnt == MAX_W) begin
        a_gnt = 1'b1;
      end else begin
        c_gnt = 1'b1;
      end
`endif
    end
  end

  assign o_cGnt  = c_gnt;
  assign o_aGnt  = a_gnt;
  assign o_stall = i_cReq & ~c_gnt;

  // Steer the winning request onto the memory port; everything is zero when
  // nobody is granted so dmem sees a quiet bus.
  always_comb begin
    o_memRead  = 1'b0;
    o_memWrite = 1'b0;
    o_addr     = 32'd0;
    o_funct3   = 3'd0;
    o_dataOut  = 32'd0;
    if (c_gnt) begin
      o_memRead  = ~i_cWrite;
      o_memWrite = i_cWrite;
      o_addr     = i_cAddr;
      o_funct3   = i_cFunct3;
      o_dataOut  = i_cWData;
    end else if (a_gnt) begin
      o_memRead  = ~i_aWrite;
      o_memWrite = i_aWrite;
      o_addr     = i_aAddr;
      o_funct3   = i_aFunct3;
      o_dataOut  = i_aWData;
    end
  end

  // Next arbitration state. The wait counter tracks consecutive aux losses
  // (fixed-priority only); the lock counter tracks consecutive locked aux
  // grants taken while the core was also asking.
  always_comb begin
    owner_next      = OWN_IDLE;
    wait_next       = 8'd0;
    lock_next       = 8'd0;
    lock_break_next = lock_hold & c_gnt;
    if (c_gnt) begin
      owner_next = OWN_CORE;
    end else if (a_gnt) begin
      owner_next = OWN_AUX;
    end
`ifndef DMEM_ARB_RR_EN
    if (i_aReq && !a_gnt) begin
      wait_next = (wait_cnt < MAX_W) ? wait_cnt + 8'd1 : wait_cnt;
    end
`endif
    if (a_gnt && i_aLock && i_cReq) begin
      lock_next = (lock_cnt < MAX_W) ? lock_cnt + 8'd1 : lock_cnt;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      owner      <= OWN_IDLE;
      wait_cnt   <= 8'd0;
      lock_cnt   <= 8'd0;
      lock_break <= 1'b0;
    end else begin
      owner      <= owner_next;
      wait_cnt   <= wait_next;
      lock_cnt   <= lock_next;
      lock_break <= lock_break_next;
    end
  end

  // Load responses: capture dmem data at the grant edge and flag it valid
  // for exactly the following cycle. The data register keeps its value until
  // the next load for the same requester.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_cRValid <= 1'b0;
      o_cRData  <= 32'd0;
      o_aRValid <= 1'b0;
      o_aRData  <= 32'd0;
    end else begin
      o_cRValid <= c_gnt & ~i_cWrite;
      o_aRValid <= a_gnt & ~i_aWrite;
      if (c_gnt && !i_cWrite) begin
        o_cRData <= i_memRData;
      end
      if (a_gnt && !i_aWrite) begin
        o_aRData <= i_memRData;
      end
    end
  end

endmodule
